// File: rtl/bayer_pkg.sv
// Shared Bayer/CFA definitions: pattern codes, colour codes, channel slots within a packed {R,G,B} word.
package bayer_pkg;

  localparam int DW_DEFAULT = 10;

  // Channel slot k occupies bits [k*DW +: DW] of a packed {R,G,B} pixel.
  localparam int R_SLOT = 2;
  localparam int G_SLOT = 1;
  localparam int B_SLOT = 0;

  typedef enum logic [1:0] {
    CFA_RGGB = 2'd0,
    CFA_GRBG = 2'd1,
    CFA_GBRG = 2'd2,
    CFA_BGGR = 2'd3
  } cfa_e;

  typedef enum logic [1:0] {
    COL_R = 2'd0,
    COL_G = 2'd1,
    COL_B = 2'd2
  } color_e;

  // pat[0] flips the column phase, pat[1] flips the row phase.
  function automatic color_e cfa_color(input logic [1:0] pat, input logic x_par, input logic y_par);
    logic cx;
    logic cy;
    cx = x_par ^ pat[0];
    cy = y_par ^ pat[1];
    if (!cx && !cy)
      return COL_R;
    else if (cx && cy)
      return COL_B;
    else
      return COL_G;
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Valid/ready register slice: output register plus one skid entry, with a registered upstream ready.
module stream_skid_buffer #(
  parameter int DATA_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
);

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;
  logic              skid_vld;
  logic              skid_nxt;
  logic [DATA_W-1:0] skid_data;
  logic              ready_q;
  logic              s_fire;
  logic              out_free;

  assign s_fire   = s_valid && ready_q;
  assign out_free = !vld_p0 || m_ready;

  // ready_q mirrors !skid_vld after reset, so an accepted beat never finds the skid occupied.
  always_comb begin
    skid_nxt = skid_vld;
    if (out_free)
      skid_nxt = 1'b0;
    else if (s_fire)
      skid_nxt = 1'b1;
  end

  // stage p0: output register, refilled from the skid entry first to keep order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      data_p0  <= '0;
      skid_vld <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      if (out_free) begin
        if (skid_vld) begin
          vld_p0  <= 1'b1;
          data_p0 <= skid_data;
        end else begin
          vld_p0 <= s_fire;
          if (s_fire)
            data_p0 <= s_data;
        end
      end
      skid_vld <= skid_nxt;
      ready_q  <= !skid_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (s_fire && !out_free)
      skid_data <= s_data;
  end

  assign s_ready = ready_q;
  assign m_valid = vld_p0;
  assign m_data  = data_p0;

endmodule

// File: rtl/rgb_to_bayer_mosaic.sv
// Re-mosaics an RGB pixel stream into a single-channel Bayer CFA stream with framing checks.
module rgb_to_bayer_mosaic
  import bayer_pkg::*;
#(
  parameter int IMG_WIDTH = 640,
  parameter int DW        = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    cfg_pattern,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [3*DW-1:0] s_rgb,
  input  logic          s_sof,
  input  logic          s_eol,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_raw,
  output logic [1:0]    m_color,
  output logic          m_sof,
  output logic          m_eol,
  output logic          err_sticky,
  input  logic          err_clr
);

  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam int PW = DW + 4;

  logic [XW-1:0] x_q;
  logic          ypar_q;
  logic [1:0]    pat_q;
  logic          err_q;

  logic          s_fire;
  logic [1:0]    pat_eff;
  logic [XW-1:0] x_eff;
  logic          ypar_eff;
  logic          line_end;
  logic          err_set;
  color_e        col;
  logic [DW-1:0] raw;
  logic [PW-1:0] payload;
  logic [PW-1:0] m_payload;

  assign s_fire = s_valid && s_ready;

  // An SOF pixel takes its own position and pattern from the resync, not from the old counters.
  always_comb begin
    pat_eff  = s_sof ? cfg_pattern : pat_q;
    x_eff    = s_sof ? '0 : x_q;
    ypar_eff = s_sof ? 1'b0 : ypar_q;
    line_end = s_eol || (x_eff == X_LAST);
    err_set  = (s_sof && (x_q != '0))
             || (s_eol && (x_eff != X_LAST))
             || (!s_eol && (x_eff == X_LAST));
    col      = cfa_color(pat_eff, x_eff[0], ypar_eff);
    raw      = '0;
    case (col)
      COL_R:   raw = s_rgb[R_SLOT*DW +: DW];
      COL_G:   raw = s_rgb[G_SLOT*DW +: DW];
      COL_B:   raw = s_rgb[B_SLOT*DW +: DW];
      default: raw = '0;
    endcase
    payload = {raw, col, s_sof, s_eol};
  end

  // stage p0 control: position counters, pattern latch, sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      ypar_q <= 1'b0;
      pat_q  <= CFA_RGGB;
      err_q  <= 1'b0;
    end else begin
      if (s_fire) begin
        pat_q <= pat_eff;
        if (line_end) begin
          x_q    <= '0;
          ypar_q <= !ypar_eff;
        end else begin
          x_q    <= x_eff + XW'(1);
          ypar_q <= ypar_eff;
        end
      end
      if (err_clr)
        err_q <= 1'b0;
      else if (s_fire && err_set)
        err_q <= 1'b1;
    end
  end

  stream_skid_buffer #(
    .DATA_W (PW)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (payload),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_payload)
  );

  assign m_raw      = m_payload[PW-1 -: DW];
  assign m_color    = m_payload[3:2];
  assign m_sof      = m_payload[1];
  assign m_eol      = m_payload[0];
  assign err_sticky = err_q;

endmodule

// File: tb/tb_rgb_to_bayer_mosaic.sv
// Scoreboard bench for rgb_to_bayer_mosaic with a 4-pixel line width.
module tb_rgb_to_bayer_mosaic;

  localparam int W  = 4;
  localparam int DW = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      cfg_pattern = 2'd0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [3*DW-1:0] s_rgb = '0;
  logic            s_sof = 1'b0;
  logic            s_eol = 1'b0;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [DW-1:0]   m_raw;
  logic [1:0]      m_color;
  logic            m_sof;
  logic            m_eol;
  logic            err_sticky;
  logic            err_clr = 1'b0;

  rgb_to_bayer_mosaic #(.IMG_WIDTH(W), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_pattern (cfg_pattern),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_rgb       (s_rgb),
    .s_sof       (s_sof),
    .s_eol       (s_eol),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_raw       (m_raw),
    .m_color     (m_color),
    .m_sof       (m_sof),
    .m_eol       (m_eol),
    .err_sticky  (err_sticky),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  logic [DW+3:0] sb[$];
  int            n_chk = 0;
  int            n_pass = 0;
  int            mr_mode = 0;  // 0: m_ready=1, 1: random, 2: m_ready=0
  int            mx = 0;
  logic          my = 1'b0;
  logic [1:0]    mpat = 2'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference CFA layouts written out as 2x2 tiles: {row0: x0 x1, row1: x0 x1}.
  function automatic logic [1:0] exp_color(input logic [1:0] p, input logic y, input logic x);
    case (p)
      2'd0:    return y ? (x ? 2'd2 : 2'd1) : (x ? 2'd1 : 2'd0);
      2'd1:    return y ? (x ? 2'd1 : 2'd2) : (x ? 2'd0 : 2'd1);
      2'd2:    return y ? (x ? 2'd1 : 2'd0) : (x ? 2'd2 : 2'd1);
      default: return y ? (x ? 2'd0 : 2'd1) : (x ? 2'd1 : 2'd2);
    endcase
  endfunction

  task automatic push_expected();
    logic [1:0]    c;
    logic [DW-1:0] r;
    if (s_sof) begin
      mx = 0;
      my = 1'b0;
      mpat = cfg_pattern;
    end
    c = exp_color(mpat, my, mx[0]);
    r = (c == 2'd0) ? s_rgb[3*DW-1:2*DW] : (c == 2'd1) ? s_rgb[2*DW-1:DW] : s_rgb[DW-1:0];
    sb.push_back({r, c, s_sof, s_eol});
    if (s_eol || mx == W - 1) begin
      mx = 0;
      my = ~my;
    end else begin
      mx++;
    end
  endtask

  // Called at a falling edge: resolves both handshakes of the coming rising edge, then advances one cycle.
  task automatic eval_cycle();
    logic [DW+3:0] e;
    case (mr_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
    if (mr_mode == 1) check_eq("ready_vs_occupancy", 32'(s_ready), 32'(sb.size() < 2));
    if (m_valid && m_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_output", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check_eq("pixel", 32'({m_raw, m_color, m_sof, m_eol}), 32'(e));
      end
    end
    if (s_valid && s_ready) push_expected();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] g, input logic [DW-1:0] b,
                      input logic sof, input logic eol);
    logic acc;
    s_valid = 1'b1;
    s_rgb   = {r, g, b};
    s_sof   = sof;
    s_eol   = eol;
    for (int n = 0; ; n++) begin
      acc = s_valid && s_ready;
      eval_cycle();
      if (acc) break;
      if (n == 100) begin
        check_eq("accept_timeout", 32'(acc), 32'd1);
        break;
      end
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb.size() > 0; n++) eval_cycle();
    check_eq("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic send_frame(input logic [1:0] p, input bit mid_change);
    cfg_pattern = p;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < W; x++) begin
        send(10'd100, 10'd200, 10'd300, (y == 0 && x == 0), (x == W - 1));
        if (mid_change) cfg_pattern = ~p;
      end
  endtask

  initial begin
    time t0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_s_ready", 32'(s_ready), 32'd0);
    check_eq("rst_m_valid", 32'(m_valid), 32'd0);
    check_eq("rst_m_raw", 32'(m_raw), 32'd0);
    check_eq("rst_m_color", 32'(m_color), 32'd0);
    check_eq("rst_m_sof", 32'(m_sof), 32'd0);
    check_eq("rst_m_eol", 32'(m_eol), 32'd0);
    check_eq("rst_err", 32'(err_sticky), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_release", 32'(s_ready), 32'd1);

    mr_mode = 0;
    t0 = $time;
    send_frame(2'd0, 1'b0);
    check_eq("rggb_cycles", 32'(($time - t0) / 10), 32'd8);
    eval_cycle();
    check_eq("rggb_latency", 32'(sb.size()), 32'd0);

    for (int p = 1; p < 4; p++) begin
      send_frame(2'(p), 1'b1);
      drain();
    end
    check_eq("no_err_clean_frames", 32'(err_sticky), 32'd0);

    mr_mode = 1;
    for (int i = 0; i < 16; i++)
      send(10'(i), 10'(i + 16), 10'(i + 32), (i == 0), (i % 4 == 3));
    drain();
    mr_mode = 0;
    drain();
    check_eq("no_err_backpressure", 32'(err_sticky), 32'd0);

    cfg_pattern = 2'd0;
    send(10'd1, 10'd2, 10'd3, 1'b1, 1'b0);
    send(10'd4, 10'd5, 10'd6, 1'b0, 1'b0);
    send(10'd7, 10'd8, 10'd9, 1'b0, 1'b1);
    check_eq("short_line_err", 32'(err_sticky), 32'd1);
    for (int x = 0; x < W; x++) send(10'(40 + x), 10'(50 + x), 10'(60 + x), 1'b0, (x == W - 1));
    drain();
    err_clr = 1'b1;
    eval_cycle();
    err_clr = 1'b0;
    check_eq("err_clr", 32'(err_sticky), 32'd0);

    for (int x = 0; x < W; x++) send(10'(70 + x), 10'(80 + x), 10'(90 + x), (x == 0), 1'b0);
    check_eq("missing_eol_err", 32'(err_sticky), 32'd1);
    for (int x = 0; x < W; x++) send(10'(110 + x), 10'(120 + x), 10'(130 + x), 1'b0, (x == W - 1));
    drain();
    err_clr = 1'b1;
    eval_cycle();
    err_clr = 1'b0;
    check_eq("err_clr2", 32'(err_sticky), 32'd0);

    cfg_pattern = 2'd0;
    send(10'd11, 10'd12, 10'd13, 1'b1, 1'b0);
    cfg_pattern = 2'd3;
    send(10'd21, 10'd22, 10'd23, 1'b1, 1'b0);
    check_eq("midsof_err", 32'(err_sticky), 32'd1);
    check_eq("midsof_color", 32'(m_color), 32'd2);
    check_eq("midsof_raw", 32'(m_raw), 32'd23);
    drain();

    mr_mode = 2;
    send(10'd31, 10'd32, 10'd33, 1'b1, 1'b0);
    send(10'd34, 10'd35, 10'd36, 1'b0, 1'b0);
    check_eq("full_m_valid", 32'(m_valid), 32'd1);
    check_eq("full_s_ready", 32'(s_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_m_valid", 32'(m_valid), 32'd0);
    check_eq("async_m_raw", 32'(m_raw), 32'd0);
    check_eq("async_m_color", 32'(m_color), 32'd0);
    check_eq("async_m_sof", 32'(m_sof), 32'd0);
    check_eq("async_s_ready", 32'(s_ready), 32'd0);
    check_eq("async_err", 32'(err_sticky), 32'd0);
    sb.delete();
    mx = 0;
    my = 1'b0;
    mpat = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    mr_mode = 0;
    cfg_pattern = 2'd2;
    eval_cycle();
    send(10'd41, 10'd42, 10'd43, 1'b0, 1'b0);
    check_eq("post_rst_color", 32'(m_color), 32'd0);
    check_eq("post_rst_raw", 32'(m_raw), 32'd41);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
